button_event_gen: RTL
=====================

Name: button_event_gen

Overview:
- Consumes per-bit debounced button levels from the debouncer stage.
- Produces single-cycle event pulses per bit: press, release and auto-repeat (typematic) while held.
- One independent lane FSM plus counter per bit.
- Output feeds control logic (menu/step/select handlers) that must act once per press, or at a steady rate while held.

Parameters:
- width, 1, number of independent button lanes
- hold_cycles, 25000000, clk cycles a button must stay held after the press pulse before the first repeat pulse; legal range ≥2
- repeat_cycles, 5000000, clk cycles between successive repeat pulses once repeating; legal range ≥2
- ctr_width, `log2(max(hold_cycles, repeat_cycles))+1, per-lane counter width (util.vh macro)

Ports:
- clk  input  1  system clock; all logic on posedge
- rst  input  1  synchronous, active-high reset
- debounced_signal  input  width  debounced button levels, already synchronous to clk
- repeat_en  input  width  per-lane enable for auto-repeat; 0 = press/release only
- press_pulse  output  width  one-cycle pulse on each new press
- release_pulse  output  width  one-cycle pulse on each release
- repeat_pulse  output  width  one-cycle pulse per repeat interval while held
- held  output  width  level: lane is in ARMED or REPEAT

Behaviour:
- All outputs are registered.
- Reset (rst=1 at a posedge):
  - every lane goes to IDLE, counter=0;
  - press_pulse, release_pulse, repeat_pulse and held are all 0 in the following cycle;
  - reset dominates all other inputs.
- Per-lane states: IDLE, ARMED, REPEAT. Let in = debounced_signal[i] sampled at the posedge.
- IDLE:
  - in=1 → ARMED, counter<=0, press_pulse<=1.
  - Otherwise stay in IDLE.
- ARMED:
  - in=0 → IDLE, release_pulse<=1, counter<=0.
  - in=1, repeat_en=1, counter==hold_cycles-1 → REPEAT, counter<=0, repeat_pulse<=1.
  - in=1, all other cases → counter<=counter+1, saturating at hold_cycles-1.
- REPEAT:
  - in=0 → IDLE, release_pulse<=1, counter<=0.
  - in=1, repeat_en=1, counter==repeat_cycles-1 → counter<=0, repeat_pulse<=1.
  - in=1, repeat_en=0 → counter holds its value; no pulses.
  - in=1, all other cases → counter<=counter+1.
- Timing:
  - Press seen at edge E0 → press_pulse high in the cycle after E0.
  - First repeat_pulse is registered at edge E0+hold_cycles, i.e. exactly hold_cycles cycles after press_pulse.
  - Subsequent repeat_pulses follow every repeat_cycles cycles.
- repeat_en deasserted in ARMED: counter saturates at hold_cycles-1. If repeat_en is later reasserted while still held, repeat_pulse fires at the next edge.
- Pulse exclusivity: press, release and repeat are mutually exclusive per lane per cycle. Each pulse lasts exactly 1 cycle unless the qualifying event recurs.
- held = 1 in ARMED and REPEAT, registered together with the state.
- Release and re-press: release in cycle n and re-press in cycle n+1 gives release_pulse, then press_pulse on consecutive cycles. The counter restarts from 0.
- Reset mid-hold:
  - All lanes return to IDLE.
  - If in=1 at the first edge after rst deasserts, a fresh press_pulse is generated.
- Lanes are fully independent; simultaneous events on different lanes are all reported in the same cycle.
- Counter arithmetic is unsigned at ctr_width bits and never wraps, because compares reset the counter before overflow.

Test Plan:
- Setup for all scenarios: width=2, hold_cycles=10, repeat_cycles=4, repeat_en=2'b11.
- Reset: assert rst 3 cycles with debounced_signal=2'b11 → all outputs 0 during reset. Releasing rst yields press_pulse=2'b11 one cycle after the first non-reset edge.
- Short tap: lane0 high 5 cycles → press_pulse[0] one cycle, release_pulse[0] one cycle 5 cycles later, zero repeat_pulse; held[0]=1 for 5 cycles.
- Long hold: lane0 high 30 cycles → repeat_pulse[0] at 10, 14, 18, 22, 26 cycles after press_pulse; then release_pulse.
- repeat_en[1]=0 while lane1 held 20 cycles → no repeat_pulse[1]. Raising repeat_en[1] at cycle 20 with the button still held → repeat_pulse[1] on the next cycle.
- Release-repress: lane0 0 for exactly 1 cycle mid-repeat → release_pulse, then press_pulse on consecutive cycles; next repeat is 10 cycles after the new press.
- Simultaneous: both lanes pressed the same cycle, lane1 released at cycle 12 → press_pulse=2'b11 together; lane1 release does not disturb lane0 repeat timing.

Source files
------------

// File: rtl/button_event_gen.sv
// button_event_gen: per-lane press/release/auto-repeat pulse generator for debounced buttons
module button_event_gen #(
    parameter int width = 1,
    parameter int hold_cycles = 25000000,
    parameter int repeat_cycles = 5000000,
    parameter int ctr_width = $clog2(hold_cycles > repeat_cycles ? hold_cycles : repeat_cycles) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] debounced_signal,
    input  logic [width-1:0] repeat_en,
    output logic [width-1:0] press_pulse,
    output logic [width-1:0] release_pulse,
    output logic [width-1:0] repeat_pulse,
    output logic [width-1:0] held
);
    typedef enum logic [1:0] {IDLE, ARMED, REPEAT} state_t;

    localparam logic [ctr_width-1:0] hold_max = ctr_width'(hold_cycles - 1);
    localparam logic [ctr_width-1:0] rep_max = ctr_width'(repeat_cycles - 1);

    genvar i;
    generate
        for (i = 0; i < width; i++) begin : g_lane
            state_t state_q, state_d;
            logic [ctr_width-1:0] ctr_q, ctr_d;
            logic press_q, release_q, repeat_q, held_q;
            logic press_d, release_d, repeat_d, held_d;
            logic in, en;

            assign in = debounced_signal[i];
            assign en = repeat_en[i];
            assign press_pulse[i] = press_q;
            assign release_pulse[i] = release_q;
            assign repeat_pulse[i] = repeat_q;
            assign held[i] = held_q;

            // State, counter and registered outputs
            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q   <= IDLE;
                    ctr_q     <= '0;
                    press_q   <= 1'b0;
                    release_q <= 1'b0;
                    repeat_q  <= 1'b0;
                    held_q    <= 1'b0;
                end else begin
                    state_q   <= state_d;
                    ctr_q     <= ctr_d;
                    press_q   <= press_d;
                    release_q <= release_d;
                    repeat_q  <= repeat_d;
                    held_q    <= held_d;
                end
            end

            // Next state and counter; ARMED saturates so a late repeat_en fires at once
            always_comb begin
                state_d = state_q;
                ctr_d = ctr_q;
                case (state_q)
                    IDLE: begin
                        state_d = in ? ARMED : IDLE;
                        ctr_d = '0;
                    end
                    ARMED: begin
                        state_d = !in ? IDLE : (en && ctr_q == hold_max) ? REPEAT : ARMED;
                        ctr_d = (!in || (en && ctr_q == hold_max)) ? '0
                              : (ctr_q == hold_max) ? ctr_q : ctr_q + 1'b1;
                    end
                    REPEAT: begin
                        state_d = in ? REPEAT : IDLE;
                        ctr_d = (!in || (en && ctr_q == rep_max)) ? '0
                              : !en ? ctr_q : ctr_q + 1'b1;
                    end
                    default: begin
                        state_d = IDLE;
                        ctr_d = '0;
                    end
                endcase
            end

            // Next values of the event pulses and the held level
            always_comb begin
                press_d = state_q == IDLE && in;
                release_d = state_q != IDLE && !in;
                repeat_d = in && en && ((state_q == ARMED && ctr_q == hold_max) ||
                                        (state_q == REPEAT && ctr_q == rep_max));
                held_d = state_d != IDLE;
            end
        end
    endgenerate
endmodule
